// File: rtl/estagio_execucao_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, mult/div
// FSM state encoding and a small op-classification helper.
package pacote_exec;

    localparam logic [4:0] ALU_OP_ADD   = 5'd0;
    localparam logic [4:0] ALU_OP_SUB   = 5'd1;
    localparam logic [4:0] ALU_OP_AND   = 5'd2;
    localparam logic [4:0] ALU_OP_OR    = 5'd3;
    localparam logic [4:0] ALU_OP_XOR   = 5'd4;
    localparam logic [4:0] ALU_OP_NOR   = 5'd5;
    localparam logic [4:0] ALU_OP_SLT   = 5'd6;
    localparam logic [4:0] ALU_OP_SLTU  = 5'd7;
    localparam logic [4:0] ALU_OP_SLL   = 5'd8;
    localparam logic [4:0] ALU_OP_SRL   = 5'd9;
    localparam logic [4:0] ALU_OP_SRA   = 5'd10;
    localparam logic [4:0] ALU_OP_LUI   = 5'd11;
    localparam logic [4:0] ALU_OP_MULT  = 5'd12;
    localparam logic [4:0] ALU_OP_MULTU = 5'd13;
    localparam logic [4:0] ALU_OP_DIV   = 5'd14;
    localparam logic [4:0] ALU_OP_DIVU  = 5'd15;
    localparam logic [4:0] ALU_OP_MFHI  = 5'd16;
    localparam logic [4:0] ALU_OP_MFLO  = 5'd17;

    // Iterative mult/div unit states
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        OCUPADO = 2'd1,
        FIM     = 2'd2
    } estado_md_t;

    // True for the four ops handled by the iterative unit
    function automatic logic eh_mult_div(input logic [4:0] op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
               (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
    endfunction

endpackage

// File: rtl/estagio_execucao_mult_div_iterativo.sv
// Iterative MULT/MULTU/DIV/DIVU unit. Signed ops work on magnitudes and fix
// the signs when HI/LO are produced. One shift-add (mult) or restoring
// subtract (div) step per OCUPADO cycle; `done` pulses in the last step and
// hi/lo are valid during that cycle only.
module mult_div_iterativo
    import pacote_exec::*;
#(
    parameter int LARGURA   = 32,
    parameter int CICLOS_MD = 32
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               op_div,
    input  logic               op_signed,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output estado_md_t         estado,
    output logic               done,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    localparam int CW = (CICLOS_MD > 1) ? $clog2(CICLOS_MD) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_MD - 1);

    estado_md_t           estado_reg, estado_next;
    logic [CW-1:0]        contador_reg, contador_next;
    // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [2*LARGURA-1:0] acc_reg, acc_next;
    logic [LARGURA-1:0]   operando_reg;
    logic [LARGURA-1:0]   dividendo_reg;
    logic                 eh_div_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 div_zero_reg;

    logic                 aceita;
    logic [LARGURA-1:0]   mag_a, mag_b;
    logic [LARGURA:0]     soma_mult;
    logic [LARGURA:0]     deslocado, diferenca;
    logic [LARGURA-1:0]   resto;
    logic [2*LARGURA-1:0] passo_mult, passo_div, passo, produto;
    logic [LARGURA-1:0]   quoc, rest;

    assign aceita = (estado_reg == OCIOSO) && start;
    assign mag_a  = (op_signed && a[LARGURA-1]) ? -a : a;
    assign mag_b  = (op_signed && b[LARGURA-1]) ? -b : b;
    assign estado = estado_reg;

    // One iteration of either algorithm, computed from the current accumulator
    always_comb begin
        soma_mult  = {1'b0, acc_reg[2*LARGURA-1:LARGURA]} +
                     (acc_reg[0] ? {1'b0, operando_reg} : '0);
        passo_mult = {soma_mult, acc_reg[LARGURA-1:1]};
        deslocado  = {acc_reg[2*LARGURA-1:LARGURA], acc_reg[LARGURA-1]};
        diferenca  = deslocado - {1'b0, operando_reg};
        resto      = diferenca[LARGURA] ? deslocado[LARGURA-1:0] : diferenca[LARGURA-1:0];
        passo_div  = {resto, acc_reg[LARGURA-2:0], ~diferenca[LARGURA]};
        passo      = eh_div_reg ? passo_div : passo_mult;
    end

    // Sign correction and divide-by-zero override on the final step
    always_comb begin
        produto = neg_q_reg ? -passo : passo;
        quoc    = passo[LARGURA-1:0];
        rest    = passo[2*LARGURA-1:LARGURA];
        if (eh_div_reg) begin
            lo = div_zero_reg ? '1 : (neg_q_reg ? -quoc : quoc);
            hi = div_zero_reg ? dividendo_reg : (neg_r_reg ? -rest : rest);
        end else begin
            hi = produto[2*LARGURA-1:LARGURA];
            lo = produto[LARGURA-1:0];
        end
    end

    // Next-state logic: accept, iterate, finish, or abort on flush
    always_comb begin
        estado_next   = estado_reg;
        contador_next = contador_reg;
        acc_next      = acc_reg;
        done          = 1'b0;
        case (estado_reg)
            OCIOSO: begin
                if (start) begin
                    estado_next   = OCUPADO;
                    contador_next = '0;
                    acc_next      = {{LARGURA{1'b0}}, mag_a};
                end
            end
            OCUPADO: begin
                if (abort) begin
                    estado_next   = OCIOSO;
                    contador_next = '0;
                end else begin
                    acc_next      = passo;
                    contador_next = contador_reg + CW'(1);
                    if (contador_reg == ULTIMO) begin
                        done          = 1'b1;
                        estado_next   = FIM;
                        contador_next = '0;
                    end
                end
            end
            FIM: begin
                estado_next = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    // State, counter, accumulator and operand capture
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg    <= OCIOSO;
            contador_reg  <= '0;
            acc_reg       <= '0;
            operando_reg  <= '0;
            dividendo_reg <= '0;
            eh_div_reg    <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            contador_reg <= contador_next;
            acc_reg      <= acc_next;
            if (aceita) begin
                operando_reg  <= mag_b;
                dividendo_reg <= a;
                eh_div_reg    <= op_div;
                neg_q_reg     <= op_signed && (a[LARGURA-1] ^ b[LARGURA-1]);
                neg_r_reg     <= op_signed && a[LARGURA-1];
                div_zero_reg  <= (b == '0);
            end
        end
    end

endmodule

// File: rtl/estagio_execucao.sv
// MIPS32 execute stage: single-cycle ALU, HI/LO registers, EX/MEM register
// and the stall request while the iterative mult/div unit is busy.
// Optional build macro EXEC_OVERFLOW_TRAP_EN adds signed-overflow trapping
// on ADD/SUB and the excecao_overflow output.
module estagio_execucao
    import pacote_exec::*;
#(
    parameter int LARGURA   = 32,
    parameter int CICLOS_MD = 32
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valido,
    input  logic [4:0]         in_alu_op,
    input  logic [LARGURA-1:0] in_a,
    input  logic [LARGURA-1:0] in_b,
    input  logic [4:0]         in_shamt,
    input  logic [4:0]         in_rd,
    input  logic               in_reg_write,
    input  logic               limpar,
    output logic               parada,
    output logic               out_valido,
    output logic [LARGURA-1:0] out_resultado,
    output logic [4:0]         out_rd,
    output logic               out_reg_write
`ifdef EXEC_OVERFLOW_TRAP_EN
    ,
    output logic               excecao_overflow
`endif
);

    logic [LARGURA-1:0] hi_reg, lo_reg;
    logic [LARGURA-1:0] md_hi, md_lo;
    logic               md_done;
    estado_md_t         md_estado;
    logic               inicio_md;
    logic               op_div, op_signed;
    logic [LARGURA-1:0] soma, diferenca;
    logic [LARGURA-1:0] resultado_alu;

    logic               out_valido_reg;
    logic [LARGURA-1:0] out_resultado_reg;
    logic [4:0]         out_rd_reg;
    logic               out_reg_write_reg;

    assign inicio_md = in_valido && eh_mult_div(in_alu_op) && !limpar;
    assign op_div    = (in_alu_op == ALU_OP_DIV)  || (in_alu_op == ALU_OP_DIVU);
    assign op_signed = (in_alu_op == ALU_OP_MULT) || (in_alu_op == ALU_OP_DIV);
    assign parada    = ((md_estado == OCIOSO) && inicio_md) || (md_estado == OCUPADO);
    assign soma      = in_a + in_b;
    assign diferenca = in_a - in_b;

    assign out_valido    = out_valido_reg;
    assign out_resultado = out_resultado_reg;
    assign out_rd        = out_rd_reg;
    assign out_reg_write = out_reg_write_reg;

    mult_div_iterativo #(
        .LARGURA   (LARGURA),
        .CICLOS_MD (CICLOS_MD)
    ) u_mult_div (
        .clock     (clock),
        .reset     (reset),
        .start     (inicio_md),
        .abort     (limpar),
        .op_div    (op_div),
        .op_signed (op_signed),
        .a         (in_a),
        .b         (in_b),
        .estado    (md_estado),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // Single-cycle ALU result; shifts and LUI operate on the rt/immediate operand
    always_comb begin
        resultado_alu = '0;
        case (in_alu_op)
            ALU_OP_ADD:  resultado_alu = soma;
            ALU_OP_SUB:  resultado_alu = diferenca;
            ALU_OP_AND:  resultado_alu = in_a & in_b;
            ALU_OP_OR:   resultado_alu = in_a | in_b;
            ALU_OP_XOR:  resultado_alu = in_a ^ in_b;
            ALU_OP_NOR:  resultado_alu = ~(in_a | in_b);
            ALU_OP_SLT:  resultado_alu = {{(LARGURA-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_OP_SLTU: resultado_alu = {{(LARGURA-1){1'b0}}, (in_a < in_b)};
            ALU_OP_SLL:  resultado_alu = in_b << in_shamt;
            ALU_OP_SRL:  resultado_alu = in_b >> in_shamt;
            ALU_OP_SRA:  resultado_alu = $unsigned($signed(in_b) >>> in_shamt);
            ALU_OP_LUI:  resultado_alu = {in_b[15:0], {(LARGURA-16){1'b0}}};
            ALU_OP_MFHI: resultado_alu = hi_reg;
            ALU_OP_MFLO: resultado_alu = lo_reg;
            default:     resultado_alu = '0;
        endcase
    end

`ifdef EXEC_OVERFLOW_TRAP_EN
    logic overflow;
    logic excecao_reg;

    assign excecao_overflow = excecao_reg;

    // Signed overflow: operands' signs make overflow possible and result sign flips
    always_comb begin
        overflow = 1'b0;
        if (in_alu_op == ALU_OP_ADD)
            overflow = (in_a[LARGURA-1] == in_b[LARGURA-1]) && (soma[LARGURA-1] != in_a[LARGURA-1]);
        else if (in_alu_op == ALU_OP_SUB)
            overflow = (in_a[LARGURA-1] != in_b[LARGURA-1]) && (diferenca[LARGURA-1] != in_a[LARGURA-1]);
    end
`endif

    // HI/LO are written only by a completed, unflushed mult/div
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (md_done) begin
            hi_reg <= md_hi;
            lo_reg <= md_lo;
        end
    end

    // EX/MEM register: flush beats everything, stall cycles insert bubbles
    always_ff @(posedge clock) begin
        if (reset || limpar) begin
            out_valido_reg    <= 1'b0;
            out_resultado_reg <= '0;
            out_rd_reg        <= '0;
            out_reg_write_reg <= 1'b0;
`ifdef EXEC_OVERFLOW_TRAP_EN
            excecao_reg       <= 1'b0;
`endif
        end else if (md_estado == FIM) begin
            out_valido_reg    <= 1'b1;
            out_resultado_reg <= '0;
            out_rd_reg        <= in_rd;
            out_reg_write_reg <= 1'b0;
`ifdef EXEC_OVERFLOW_TRAP_EN
            excecao_reg       <= 1'b0;
`endif
        end else if (parada || !in_valido) begin
            out_valido_reg    <= 1'b0;
            out_resultado_reg <= '0;
            out_rd_reg        <= '0;
            out_reg_write_reg <= 1'b0;
`ifdef EXEC_OVERFLOW_TRAP_EN
            excecao_reg       <= 1'b0;
`endif
        end else begin
            out_valido_reg    <= 1'b1;
            out_resultado_reg <= resultado_alu;
            out_rd_reg        <= in_rd;
`ifdef EXEC_OVERFLOW_TRAP_EN
            out_reg_write_reg <= in_reg_write && !overflow;
            excecao_reg       <= overflow;
`else
            out_reg_write_reg <= in_reg_write;
`endif
        end
    end

endmodule

// File: tb/tb_estagio_execucao.sv
// Self-checking bench for estagio_execucao: directed corner cases plus
// randomized single-cycle and mult/div traffic against a behavioural model.
module tb_estagio_execucao;
    import pacote_exec::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valido;
    logic [4:0]  in_alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        limpar;
    logic        parada;
    logic        out_valido;
    logic [31:0] out_resultado;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef EXEC_OVERFLOW_TRAP_EN
    logic        excecao_overflow;
`endif

    int n_comparados  = 0;
    int n_divergentes = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clock = ~clock;

    estagio_execucao dut (
        .clock         (clock),
        .reset         (reset),
        .in_valido     (in_valido),
        .in_alu_op     (in_alu_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_shamt      (in_shamt),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .limpar        (limpar),
        .parada        (parada),
        .out_valido    (out_valido),
        .out_resultado (out_resultado),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef EXEC_OVERFLOW_TRAP_EN
        ,
        .excecao_overflow (excecao_overflow)
`endif
    );

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comparados++;
        if (obs !== esp) begin
            n_divergentes++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    function automatic logic [31:0] modelo_alu(input logic [4:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] todos;
        logic [31:0] t;
        todos = 32'hFFFF_FFFF;
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_AND:  return a & b;
            ALU_OP_OR:   return a | b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_NOR:  return ~(a | b);
            ALU_OP_SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLL:  return b << sh;
            ALU_OP_SRL:  return b >> sh;
            ALU_OP_SRA: begin
                t = b >> sh;
                if (b[31]) t = t | ~(todos >> sh);
                return t;
            end
            ALU_OP_LUI:  return b * 32'd65536;
            ALU_OP_MFHI: return m_hi;
            ALU_OP_MFLO: return m_lo;
            default:     return 32'h0;
        endcase
    endfunction

    function automatic logic modelo_ovf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (op == ALU_OP_ADD)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == ALU_OP_SUB) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic modelo_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sq, sr;
        logic [63:0] up;
        case (op)
            ALU_OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            ALU_OP_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            ALU_OP_DIVU: begin
                if (b == 32'h0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            default: begin
                if (b == 32'h0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    up = sq; m_lo = up[31:0];
                    up = sr; m_hi = up[31:0];
                end
            end
        endcase
    endtask

    // Drive one non-mult/div instruction for one edge and check EX/MEM
    task automatic exec_simples(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [4:0] rd, input logic rw,
                                input logic val, input logic limp);
        logic        e_val, e_rw, e_exc;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        in_alu_op = op; in_a = a; in_b = b; in_shamt = sh; in_rd = rd;
        in_reg_write = rw; in_valido = val; limpar = limp;
        e_val = 1'b0; e_rw = 1'b0; e_exc = 1'b0; e_res = 32'h0; e_rd = 5'd0;
        if (val && !limp) begin
            e_val = 1'b1; e_res = modelo_alu(op, a, b, sh); e_rd = rd; e_rw = rw;
`ifdef EXEC_OVERFLOW_TRAP_EN
            e_exc = modelo_ovf(op, a, b);
            if (e_exc) e_rw = 1'b0;
`endif
        end
        @(posedge clock); #1;
        $display("op=%0d a=%08h b=%08h sh=%0d rd=%0d v=%0b fl=%0b -> res=%08h v=%0b rw=%0b",
                 op, a, b, sh, rd, val, limp, out_resultado, out_valido, out_reg_write);
        verificar("valido", out_valido, e_val);
        verificar("resultado", out_resultado, e_res);
        verificar("rd", out_rd, e_rd);
        verificar("reg_write", out_reg_write, e_rw);
        verificar("parada_simples", parada, 0);
`ifdef EXEC_OVERFLOW_TRAP_EN
        verificar("excecao", excecao_overflow, e_exc);
`endif
        limpar = 1'b0;
    endtask

    // Run a mult/div to completion; checks stall length, bubble and retirement
    task automatic exec_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int ciclos;
        in_alu_op = op; in_a = a; in_b = b; in_shamt = 5'd0; in_rd = 5'($urandom_range(0, 31));
        in_reg_write = 1'b0; in_valido = 1'b1; limpar = 1'b0;
        #1;
        verificar("parada_ini", parada, 1);
        ciclos = 0;
        while (parada && ciclos < 100) begin
            ciclos++;
            @(posedge clock); #1;
            if (ciclos == 1) verificar("bolha_md", out_valido, 0);
        end
        verificar("ciclos_parada", ciclos, 33);
        @(posedge clock); #1;
        verificar("md_valido", out_valido, 1);
        verificar("md_reg_write", out_reg_write, 0);
        modelo_md(op, a, b);
        $display("md op=%0d a=%08h b=%08h stall=%0d -> hi=%08h lo=%08h (model)", op, a, b, ciclos, m_hi, m_lo);
        in_valido = 1'b0;
        exec_simples(ALU_OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        exec_simples(ALU_OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] ra, rb;
        int          r;

        reset = 1'b1; in_valido = 1'b0; in_alu_op = 5'd0; in_a = 32'h0; in_b = 32'h0;
        in_shamt = 5'd0; in_rd = 5'd0; in_reg_write = 1'b0; limpar = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        verificar("rst_valido", out_valido, 0);
        verificar("rst_resultado", out_resultado, 0);
        verificar("rst_rd", out_rd, 0);
        verificar("rst_reg_write", out_reg_write, 0);
        verificar("rst_parada", parada, 0);
        reset = 1'b0;
        exec_simples(ALU_OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        exec_simples(ALU_OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);

        // Directed single-cycle corners
        exec_simples(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        verificar("add_ovf_res", out_resultado, 32'h8000_0000);
        exec_simples(ALU_OP_SRA, 32'h0, 32'h8000_0000, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0);
        verificar("sra_const", out_resultado, 32'hF800_0000);
        exec_simples(ALU_OP_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        verificar("sltu_const", out_resultado, 32'h1);
        exec_simples(ALU_OP_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        verificar("slt_const", out_resultado, 32'h0);
        exec_simples(ALU_OP_LUI, 32'h0, 32'h1234_ABCD, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        exec_simples(ALU_OP_ADD, 32'h5, 32'h6, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1);
        exec_simples(ALU_OP_ADD, 32'h5, 32'h6, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);

        // Directed mult/div
        exec_md(ALU_OP_MULT, 32'hFFFF_FFFD, 32'd7);
        verificar("mult_hi_const", out_resultado, 32'hFFFF_FFFF);
        exec_md(ALU_OP_DIVU, 32'd100, 32'd0);
        verificar("divu0_hi_const", out_resultado, 32'd100);
        exec_md(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        verificar("div_hi_const", out_resultado, 32'hFFFF_FFFF);
        exec_md(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        exec_md(ALU_OP_DIV, 32'hFFFF_FF00, 32'd0);
        exec_md(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Flush at busy cycle 10 of a DIVU: HI/LO keep their values
        in_alu_op = ALU_OP_DIVU; in_a = 32'd12345; in_b = 32'd7; in_valido = 1'b1; in_reg_write = 1'b0;
        @(posedge clock); #1;
        repeat (9) begin @(posedge clock); #1; end
        limpar = 1'b1; in_valido = 1'b0;
        #1;
        verificar("abort_parada_antes", parada, 1);
        @(posedge clock); #1;
        limpar = 1'b0;
        $display("abort divu at busy cycle 10 -> parada=%0b valido=%0b", parada, out_valido);
        verificar("abort_parada", parada, 0);
        verificar("abort_valido", out_valido, 0);
        verificar("abort_resultado", out_resultado, 0);
        exec_simples(ALU_OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        exec_simples(ALU_OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);

        // Randomized single-cycle traffic
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 13);
            op = (r < 12) ? 5'(r) : ((r == 12) ? ALU_OP_MFHI : ALU_OP_MFLO);
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            exec_simples(op, ra, rb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
        end

        // Randomized mult/div
        for (int i = 0; i < 6; i++) begin
            op = 5'(12 + $urandom_range(0, 3));
            rb = $urandom;
            if (i == 2) rb = 32'h0;
            exec_md(op, $urandom, rb);
        end

        // Reset at busy cycle 20 of a MULT
        in_alu_op = ALU_OP_MULT; in_a = 32'd1000; in_b = 32'd1000; in_valido = 1'b1;
        @(posedge clock); #1;
        repeat (19) begin @(posedge clock); #1; end
        reset = 1'b1; in_valido = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        $display("reset at busy cycle 20 -> parada=%0b valido=%0b res=%08h", parada, out_valido, out_resultado);
        verificar("rstmid_parada", parada, 0);
        verificar("rstmid_valido", out_valido, 0);
        verificar("rstmid_resultado", out_resultado, 0);
        verificar("rstmid_rd", out_rd, 0);
        verificar("rstmid_reg_write", out_reg_write, 0);
        exec_simples(ALU_OP_ADD, 32'd40, 32'd2, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
        verificar("add_after_rst", out_resultado, 32'd42);
        exec_simples(ALU_OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
        exec_simples(ALU_OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comparados, n_divergentes);
        $finish;
    end

endmodule
